// File: rtl/retire_pkg.sv
// Shared retire-trace definitions: retire kinds, golden record layout,
// error codes, checker state and the per-kind address compare rule.
package retire_pkg;

  typedef enum logic [3:0] {
    RK_SUB  = 4'd0,
    RK_MOVL = 4'd1,
    RK_MOVH = 4'd2,
    RK_JZ   = 4'd3,
    RK_JNZ  = 4'd4,
    RK_JS   = 4'd5,
    RK_JNS  = 4'd6,
    RK_LD   = 4'd7,
    RK_ST   = 4'd8
  } retire_kind_e;

  localparam int REC_FIELD_W  = 16;
  localparam int REC_DATA_LSB = 0;
  localparam int REC_ADDR_LSB = 16;
  localparam int REC_PC_LSB   = 32;
  localparam int REC_KIND_LSB = 48;
  localparam int REC_KIND_W   = 4;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_MISMATCH = 3'd1;
  localparam logic [2:0] ERR_UNDERRUN = 3'd2;
  localparam logic [2:0] ERR_EXTRA    = 3'd3;
  localparam logic [2:0] ERR_SHORT    = 3'd4;
  localparam logic [2:0] ERR_BADKIND  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2,
    ST_PASS = 2'd3
  } chk_state_e;

  function automatic logic kind_valid(input logic [REC_KIND_W-1:0] k);
    return k <= RK_ST;
  endfunction

  // Register kinds carry an index in addr[3:0]; stores a full address; jumps nothing.
  function automatic logic addr_match(input logic [REC_KIND_W-1:0] k,
                                      input logic [REC_FIELD_W-1:0] got,
                                      input logic [REC_FIELD_W-1:0] exp);
    logic m;
    case (k)
      RK_ST:                        m = (got == exp);
      RK_SUB, RK_MOVL, RK_MOVH, RK_LD: m = (got[3:0] == exp[3:0]);
      default:                      m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/retire_rec_fifo.sv
// Two-entry golden-record FIFO; push and pop may occur in the same cycle.
module retire_rec_fifo #(
  parameter int W = 52
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_valid,
  output logic [1:0]   o_occ
);

  logic [1:0][W-1:0] r_mem;
  logic              r_rd;
  logic              r_wr;
  logic [1:0]        r_occ;
  logic              w_push;
  logic              w_pop;

  assign w_pop  = i_pop && (r_occ != 2'd0);
  assign w_push = i_push && ((r_occ != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_occ <= 2'd0;
    end else begin
      if (w_push) r_wr <= ~r_wr;
      if (w_pop)  r_rd <= ~r_rd;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  assign o_head  = r_mem[r_rd];
  assign o_valid = (r_occ != 2'd0);
  assign o_occ   = r_occ;

endmodule

// File: rtl/retire_trace_checker.sv
// Replays a golden retirement trace from RAM against the live retire stream
// and latches the first divergence with full diagnostics.
module retire_trace_checker
  import retire_pkg::*;
#(
  parameter int IDX_W = 12,
  parameter int REC_W = 52
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ret_valid,
  input  logic [3:0]       ret_kind,
  input  logic [15:0]      ret_pc,
  input  logic [15:0]      ret_addr,
  input  logic [15:0]      ret_data,
  input  logic             halt,
  input  logic [IDX_W-1:0] exp_count,
  output logic [IDX_W-1:0] exp_raddr,
  output logic             exp_ren,
  input  logic [REC_W-1:0] exp_rdata,
  output logic             done,
  output logic             pass,
  output logic [2:0]       err_code,
  output logic [IDX_W-1:0] err_index,
  output logic [REC_W-1:0] err_got,
  output logic [REC_W-1:0] err_exp,
  output logic [IDX_W-1:0] ret_count
);

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  chk_state_e       r_state, w_nstate;
  logic [IDX_W-1:0] r_fptr;
  logic             r_inflight;
  logic             r_done, r_pass;
  logic [2:0]       r_err_code;
  logic [IDX_W-1:0] r_err_index, r_ret_count;
  logic [REC_W-1:0] r_err_got, r_err_exp;

  logic [REC_W-1:0] w_head, w_rec_got;
  logic             w_head_vld, w_match, w_pop, w_pass, w_issue;
  logic [1:0]       w_occ;
  logic [2:0]       w_occ_sum, w_err;
  logic [IDX_W-1:0] w_cnt_inc, w_cnt_post;

  retire_rec_fifo #(.W(REC_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_din   (exp_rdata),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_valid (w_head_vld),
    .o_occ   (w_occ)
  );

  assign w_rec_got = {ret_kind, ret_pc, ret_addr, ret_data};
  assign w_cnt_inc = (r_ret_count == '1) ? r_ret_count : r_ret_count + ONE;

  assign w_match = (ret_kind == w_head[REC_KIND_LSB +: REC_KIND_W])
                && (ret_pc   == w_head[REC_PC_LSB   +: REC_FIELD_W])
                && (ret_data == w_head[REC_DATA_LSB +: REC_FIELD_W])
                && addr_match(ret_kind, ret_addr, w_head[REC_ADDR_LSB +: REC_FIELD_W]);

  // Counting this cycle's pop lets a refill issue alongside every retire.
  assign w_occ_sum = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue   = (r_state == ST_RUN) && (w_occ_sum < 3'd2) && (r_fptr < exp_count);
  assign exp_ren   = w_issue;
  assign exp_raddr = r_fptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nstate;
  end

  // Retire is judged first; halt then sees the post-retire count.
  always_comb begin
    w_nstate   = r_state;
    w_err      = ERR_NONE;
    w_pop      = 1'b0;
    w_pass     = 1'b0;
    w_cnt_post = r_ret_count;
    if (r_state == ST_IDLE || r_state == ST_RUN) begin
      if (r_state == ST_IDLE) w_nstate = ST_RUN;
      if (ret_valid) begin
        if (!kind_valid(ret_kind))        w_err = ERR_BADKIND;
        else if (r_ret_count >= exp_count) w_err = ERR_EXTRA;
        else if (!w_head_vld)             w_err = ERR_UNDERRUN;
        else if (!w_match)                w_err = ERR_MISMATCH;
        else begin
          w_pop      = 1'b1;
          w_cnt_post = w_cnt_inc;
        end
      end
      if (w_err == ERR_NONE && halt) begin
        if (w_cnt_post < exp_count) w_err  = ERR_SHORT;
        else                        w_pass = 1'b1;
      end
      if (w_err != ERR_NONE) w_nstate = ST_FAIL;
      else if (w_pass)       w_nstate = ST_PASS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fptr      <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_index <= '0;
      r_err_got   <= '0;
      r_err_exp   <= '0;
      r_ret_count <= '0;
    end else begin
      r_inflight  <= w_issue;
      if (w_issue) r_fptr <= r_fptr + ONE;
      r_ret_count <= w_cnt_post;
      if (w_err != ERR_NONE) begin
        r_done      <= 1'b1;
        r_pass      <= 1'b0;
        r_err_code  <= w_err;
        r_err_index <= w_cnt_post;
        r_err_got   <= ret_valid  ? w_rec_got : '0;
        r_err_exp   <= w_head_vld ? w_head    : '0;
      end else if (w_pass) begin
        r_done <= 1'b1;
        r_pass <= 1'b1;
      end
    end
  end

  assign done      = r_done;
  assign pass      = r_pass;
  assign err_code  = r_err_code;
  assign err_index = r_err_index;
  assign err_got   = r_err_got;
  assign err_exp   = r_err_exp;
  assign ret_count = r_ret_count;

endmodule
